// File: rtl/mem_master_pkg.sv
// Shared types and constants for the mem_master controller.
// Holds the controller state enum, the memory read-latency constant and the
// read-pipeline depth derived from it, plus the per-beat tag carried down the pipe.
package mem_master_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // The memory registers its read output: data appears one cycle after the address.
  localparam int READ_LATENCY = 1;

  // One stage per cycle of memory latency, plus the output capture stage.
  localparam int RD_PIPE_DEPTH = READ_LATENCY + 1;

  // Tag that follows each issued read address down the pipe.
  typedef struct packed {
    logic vld;
    logic last;
  } pipe_tag_t;

endpackage

// File: rtl/mem_master_if.sv
// Request/response and memory-port bundle for mem_master.
// master: controller view (drives req_ready, rsp_*, wr_done, mem_we/addr/data).
// slave:  requester + memory view (drives req_*, mem_out).
interface mem_master_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 4
) ();

  // Request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [LEN_WIDTH-1:0]  req_len;

  // Response channel (no backpressure)
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  wr_done;

  // Memory port
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_out;

  modport master (
    input  req_valid, req_we, req_addr, req_data, req_len, mem_out,
    output req_ready, rsp_valid, rsp_data, rsp_last, wr_done,
           mem_we, mem_addr, mem_data
  );

  modport slave (
    output req_valid, req_we, req_addr, req_data, req_len, mem_out,
    input  req_ready, rsp_valid, rsp_data, rsp_last, wr_done,
           mem_we, mem_addr, mem_data
  );

endinterface

// File: rtl/mem_rd_pipe.sv
// Purpose: valid/last delay line tracking issued read addresses, plus rsp_data capture.
// Latency: DEPTH cycles from issue to rsp_valid; rsp_data captured one edge after mem_out is valid.
// Backpressure: none; one beat in, one beat out per cycle.
// Ports: issue_vld/issue_last mark an address presented this cycle; mem_out is the
// memory's registered read data; rsp_valid/rsp_last/rsp_data are registered outputs.
module mem_rd_pipe
  import mem_master_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = RD_PIPE_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_vld,
  input  logic                  issue_last,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic                  rsp_valid,
  output logic                  rsp_last,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  pipe_tag_t [DEPTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  always_comb begin
    tag_d         = tag_q;
    tag_d[0].vld  = issue_vld;
    tag_d[0].last = issue_vld && issue_last;
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    // The stage just before the output lines up with mem_out being valid.
    data_d = data_q;
    if (tag_q[DEPTH-2].vld) begin
      data_d = mem_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign rsp_valid = tag_q[DEPTH-1].vld;
  assign rsp_last  = tag_q[DEPTH-1].last;
  assign rsp_data  = data_q;

endmodule

// File: rtl/mem_master.sv
// Purpose: initiator-side controller driving a single-port synchronous memory from a valid/ready request port.
// Latency: write -> wr_done 2 cycles after accept; read -> first rsp_valid 3 cycles after accept, beats back-to-back.
// Backpressure: req_ready only in IDLE; responses have no backpressure.
// Ports: clk, rst_n (async active-low) plus the mem_master_if master modport carrying
// req_* (request), rsp_*/wr_done (responses) and mem_we/mem_addr/mem_data/mem_out (memory port).
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_master_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  wr_done_q, wr_done_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

  logic                  accept;
  logic                  issue_vld;
  logic                  issue_last;
  logic                  pipe_rsp_valid;
  logic                  pipe_rsp_last;
  logic [DATA_WIDTH-1:0] pipe_rsp_data;

  assign accept     = bus.req_valid && req_ready_q;
  // Every cycle in READ presents one address; cnt_q==0 marks the final one.
  assign issue_vld  = (state_q == ST_READ);
  assign issue_last = issue_vld && (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mem_addr_d = bus.req_addr;
          if (bus.req_we) begin
            state_d    = ST_WRITE;
            mem_data_d = bus.req_data;
          end else begin
            state_d = ST_READ;
            cnt_d   = bus.req_len;
          end
        end
      end
      ST_WRITE: begin
        // The memory commits on the edge closing this cycle.
        state_d   = ST_IDLE;
        wr_done_d = 1'b1;
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d      = cnt_q - LEN_ONE;
          mem_addr_d = mem_addr_q + ADDR_ONE;  // wraps modulo 2**ADDR_WIDTH
        end
      end
      ST_DRAIN: begin
        // The last beat is on the outputs this cycle, so the pipe is empty after it.
        if (pipe_rsp_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs follow the next state so they line up with it.
    mem_we_d    = (state_d == ST_WRITE);
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      wr_done_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      wr_done_q   <= wr_done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RD_PIPE_DEPTH)
  ) u_rd_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_vld  (issue_vld),
    .issue_last (issue_last),
    .mem_out    (bus.mem_out),
    .rsp_valid  (pipe_rsp_valid),
    .rsp_last   (pipe_rsp_last),
    .rsp_data   (pipe_rsp_data)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.rsp_valid = pipe_rsp_valid;
  assign bus.rsp_last  = pipe_rsp_last;
  assign bus.rsp_data  = pipe_rsp_data;

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator-side controller for the single-port synchronous memory: accepts read/write requests over a valid/ready handshake and drives that memory's we/addr/data port.
- Captures the memory's registered read output, accounting for its 1-cycle read latency.
- Reads support bursts of up to 2**LEN_WIDTH consecutive words; writes are single-beat.
- Sits between the CPU/datapath and the memory instance.

Parameters:
- ADDR_WIDTH, 6, memory address width; must match the memory instance.
- DATA_WIDTH, 16, memory word width; must match the memory instance.
- LEN_WIDTH, 4, width of the burst-length field; a read burst is req_len+1 words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  start address.
- req_data  input  DATA_WIDTH  write data, ignored for reads.
- req_len  input  LEN_WIDTH  read burst length minus 1, ignored for writes.
- rsp_valid  output  1  read data beat valid, one-cycle pulse per beat; no backpressure.
- rsp_data  output  DATA_WIDTH  read data.
- rsp_last  output  1  high with the final beat of a burst.
- wr_done  output  1  one-cycle pulse when a write has been committed.
- mem_we  output  1  to memory we.
- mem_addr  output  ADDR_WIDTH  to memory addr.
- mem_data  output  DATA_WIDTH  to memory data.
- mem_out  input  DATA_WIDTH  from memory out; valid the cycle after an address is presented.

Behaviour:
- Outputs and reset:
  - All outputs are registered.
  - On rst_n=0, asynchronously: state=IDLE, req_ready=0, and rsp_valid, rsp_data, rsp_last, wr_done, mem_we, mem_addr, mem_data all cleared to 0.
  - req_ready rises in the first cycle after reset release.
- States: IDLE, WRITE, READ, DRAIN.
- Accept: a request is accepted on an edge where req_valid && req_ready. req_ready=1 only in IDLE. The request fields are latched on the accept edge.
- IDLE, accept with req_we=1:
  - Go to WRITE.
  - Next cycle: mem_we=1, mem_addr=req_addr, mem_data=req_data, req_ready=0.
- WRITE (one cycle):
  - The memory commits on the closing edge.
  - Next cycle: mem_we=0, wr_done=1 for one cycle, state=IDLE, req_ready=1.
  - Write throughput is one write per 2 cycles.
- IDLE, accept with req_we=0:
  - Go to READ.
  - Beat counter loads req_len; mem_addr=req_addr, mem_we=0.
- READ:
  - One address per cycle; mem_addr increments by 1 per cycle, wrapping modulo 2**ADDR_WIDTH (e.g. 63 -> 0 at default width).
  - After req_len+1 addresses have been presented, go to DRAIN.
- Read pipeline:
  - Stage 1: a 2-stage valid/last shift register tracks each issued address.
  - Stage 2: rsp_data <= mem_out on the edge after mem_out becomes valid.
  - Latency: the first rsp_valid occurs 3 cycles after the accept edge.
  - Beats are back-to-back; rsp_last accompanies beat req_len+1.
- DRAIN:
  - Wait until the pipeline is empty, i.e. the cycle in which rsp_last is driven.
  - Next cycle: IDLE with req_ready=1.
- Request hold: request inputs are don't-care while req_ready=0.
- Idle values: mem_we=0 whenever not in WRITE; mem_addr and mem_data hold their last values when idle.
- Read-after-write to the same address returns the new data; this is guaranteed by the WRITE->IDLE sequencing.
- Reset mid-operation:
  - An outstanding burst is aborted; no rsp_valid or wr_done appears after reset release.
  - A write whose mem_we is cleared by reset before its commit edge is lost.
- Unused bits: req_len is ignored for writes.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WRITE, READ, DRAIN);
  - the READ_LATENCY=1 constant for the memory's read latency;
  - the pipeline depth constant of 2 derived from it.
- One natural sub-module, mem_rd_pipe: a parameterised valid/last delay line plus data capture register, with async active-low reset.

Test Plan:
- Write then read: write addr 5 data 16'hBEEF, then read addr 5 len 0 -> wr_done pulse 2 cycles after accept; rsp_valid 3 cycles after the read accept with rsp_data=16'hBEEF and rsp_last=1.
- Burst read: preload mem[10..13]=1,2,3,4; read addr 10 len 3 -> 4 consecutive rsp_valid beats 1,2,3,4, rsp_last only on 4; req_ready low until the cycle after the last beat.
- Address wrap: preload mem[62]=A, mem[63]=B, mem[0]=C; read addr 62 len 2 -> mem_addr sequence 62,63,0; responses A,B,C.
- Back-to-back writes with req_valid held high: 3 writes to addrs 1,2,3 -> one accept every 2 cycles, 3 wr_done pulses, memory contents verified by a later burst read.
- Reset mid-burst: assert rst_n=0 during beat 2 of a len-7 read -> all outputs 0 immediately; no rsp_valid after release; req_ready=1 one cycle after release.
- Handshake: req_valid pulsed while req_ready=0 -> ignored; no extra access on mem_addr/mem_we.
